// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the post-commit store buffer.
// Entry layout, drain FSM states and depth constants live here.
package store_buffer_pkg;

    localparam int ROB_DEPTH     = 16;
    localparam int SB_DEPTH      = 4;
    localparam int SB_DEPTH_BITS = $clog2(SB_DEPTH);

    localparam int SB_ADDR_WIDTH = 32;
    localparam int SB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [SB_ADDR_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_REQ,
        SB_WAIT
    } sb_state_t;

endpackage

// File: rtl/store_buffer.sv
// Post-commit store FIFO draining to the D-cache one write at a time; a request is presented the cycle after commit.
// Stalls the ROB when full; forwards the youngest matching store data to loads combinationally.
module store_buffer #(
    parameter int SB_DEPTH   = store_buffer_pkg::SB_DEPTH,
    parameter int ADDR_WIDTH = store_buffer_pkg::SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = store_buffer_pkg::SB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  sb_stall,
    output logic                  dc_req_valid,
    output logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic [DATA_WIDTH-1:0] dc_req_data,
    input  logic                  dc_req_ready,
    input  logic                  dc_wr_done,
    input  logic [ADDR_WIDTH-1:0] ld_lookup_addr,
    output logic                  ld_fwd_hit,
    output logic [DATA_WIDTH-1:0] ld_fwd_data,
    output logic                  sb_empty
);
    import store_buffer_pkg::*;

    localparam int IDX_W = $clog2(SB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Byte-offset bits are masked off so forwarding compares whole words.
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    sb_entry_t             mem [SB_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, count;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  empty, full, push, pop;
    sb_state_t             state, state_nxt;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign push   = mem_wr_en && !full;

    assign sb_stall     = full;
    assign sb_empty     = empty && (state == SB_IDLE);
    assign dc_req_valid = (state == SB_REQ);
    assign dc_req_addr  = ADDR_WIDTH'(mem[rd_idx].addr);
    assign dc_req_data  = DATA_WIDTH'(mem[rd_idx].data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_idx] <= sb_entry_t'{addr: SB_ADDR_WIDTH'(mem_wr_addr),
                                           data: SB_DATA_WIDTH'(mem_wr_data)};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A store accepted this cycle already counts as buffered, so the request goes out next cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            SB_IDLE: begin
                if (!empty || push) begin
                    state_nxt = SB_REQ;
                end
            end
            SB_REQ: begin
                if (dc_req_ready) begin
                    state_nxt = SB_WAIT;
                end
            end
            SB_WAIT: begin
                if (dc_wr_done) begin
                    pop       = 1'b1;
                    state_nxt = ((count > PTR_W'(1)) || push) ? SB_REQ : SB_IDLE;
                end
            end
            default: state_nxt = SB_IDLE;
        endcase
    end

    // Walk oldest to youngest so the youngest match is the one left standing; the incoming store beats all.
    always_comb begin
        logic [IDX_W-1:0]      idx;
        logic [ADDR_WIDTH-1:0] ent_addr;
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        idx         = '0;
        ent_addr    = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx      = rd_idx + IDX_W'(k);
            ent_addr = ADDR_WIDTH'(mem[idx].addr);
            if ((PTR_W'(k) < count) && (((ent_addr ^ ld_lookup_addr) & WORD_MASK) == '0)) begin
                ld_fwd_hit  = 1'b1;
                ld_fwd_data = DATA_WIDTH'(mem[idx].data);
            end
        end
        if (push && (((mem_wr_addr ^ ld_lookup_addr) & WORD_MASK) == '0)) begin
            ld_fwd_hit  = 1'b1;
            ld_fwd_data = mem_wr_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain handshake, full/stall, forwarding, reset, wrap.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        sb_stall;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic        dc_req_ready;
    logic        dc_wr_done;
    logic [31:0] ld_lookup_addr;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        sb_empty;

    int checks   = 0;
    int failures = 0;

    store_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .sb_stall       (sb_stall),
        .dc_req_valid   (dc_req_valid),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_ready   (dc_req_ready),
        .dc_wr_done     (dc_wr_done),
        .ld_lookup_addr (ld_lookup_addr),
        .ld_fwd_hit     (ld_fwd_hit),
        .ld_fwd_data    (ld_fwd_data),
        .sb_empty       (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] a, input logic [31:0] d);
        mem_wr_en   = 1'b1;
        mem_wr_addr = a;
        mem_wr_data = d;
        tick();
        mem_wr_en   = 1'b0;
        #1;
    endtask

    // Waits (bounded) for a request, checks it, then completes the cache round trip.
    task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!dc_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, dc_req_valid}, 32'd1);
        chk({tag, "_addr"}, dc_req_addr, a);
        chk({tag, "_data"}, dc_req_data, d);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        #1;
        chk({tag, "_wait_novalid"}, {31'd0, dc_req_valid}, 32'd0);
        dc_wr_done = 1'b1;
        tick();
        dc_wr_done = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        mem_wr_en      = 1'b0;
        mem_wr_addr    = '0;
        mem_wr_data    = '0;
        dc_req_ready   = 1'b0;
        dc_wr_done     = 1'b0;
        ld_lookup_addr = '0;
        tick();
        tick();
        chk("rst_stall", {31'd0, sb_stall}, 32'd0);
        chk("rst_valid", {31'd0, dc_req_valid}, 32'd0);
        chk("rst_addr", dc_req_addr, 32'd0);
        chk("rst_data", dc_req_data, 32'd0);
        chk("rst_hit", {31'd0, ld_fwd_hit}, 32'd0);
        chk("rst_fwd", ld_fwd_data, 32'd0);
        chk("rst_empty", {31'd0, sb_empty}, 32'd1);
        rst = 1'b0;
        tick();

        // Single store, request held while the cache is not ready.
        commit(32'h100, 32'hDEAD);
        chk("t1_valid", {31'd0, dc_req_valid}, 32'd1);
        chk("t1_addr", dc_req_addr, 32'h100);
        chk("t1_data", dc_req_data, 32'hDEAD);
        chk("t1_notempty", {31'd0, sb_empty}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_valid", {31'd0, dc_req_valid}, 32'd1);
            chk("t1_hold_addr", dc_req_addr, 32'h100);
            chk("t1_hold_data", dc_req_data, 32'hDEAD);
        end
        drain_one("t1_drain", 32'h100, 32'hDEAD);
        chk("t1_empty", {31'd0, sb_empty}, 32'd1);

        // Fill to full with the cache stalled; a fifth commit must wait.
        for (int i = 0; i < 4; i++) begin
            commit(32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        chk("t2_full_stall", {31'd0, sb_stall}, 32'd1);
        mem_wr_en      = 1'b1;
        mem_wr_addr    = 32'h410;
        mem_wr_data    = 32'hA4;
        ld_lookup_addr = 32'h410;
        #1;
        chk("t2_rejected_nofwd", {31'd0, ld_fwd_hit}, 32'd0);
        tick();
        chk("t2_still_stall", {31'd0, sb_stall}, 32'd1);
        chk("t2_head_addr", dc_req_addr, 32'h400);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        dc_wr_done   = 1'b1;
        tick();
        dc_wr_done   = 1'b0;
        #1;
        chk("t2_stall_fell", {31'd0, sb_stall}, 32'd0);
        tick();
        mem_wr_en = 1'b0;
        #1;
        chk("t2_retry_full", {31'd0, sb_stall}, 32'd1);
        chk("t2_retry_fwd_hit", {31'd0, ld_fwd_hit}, 32'd1);
        chk("t2_retry_fwd_data", ld_fwd_data, 32'hA4);
        for (int i = 1; i < 5; i++) begin
            drain_one("t2_order", 32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        chk("t2_empty", {31'd0, sb_empty}, 32'd1);

        // Youngest match wins; the byte offset is ignored; a different word misses.
        commit(32'h200, 32'h11);
        commit(32'h200, 32'h22);
        ld_lookup_addr = 32'h200;
        #1;
        chk("t3_hit", {31'd0, ld_fwd_hit}, 32'd1);
        chk("t3_youngest", ld_fwd_data, 32'h22);
        ld_lookup_addr = 32'h203;
        #1;
        chk("t3_byte_off", ld_fwd_data, 32'h22);
        ld_lookup_addr = 32'h204;
        #1;
        chk("t3_miss_hit", {31'd0, ld_fwd_hit}, 32'd0);
        chk("t3_miss_data", ld_fwd_data, 32'd0);

        // Same-cycle commit is forwarded, then via the FIFO entry.
        ld_lookup_addr = 32'h300;
        mem_wr_en      = 1'b1;
        mem_wr_addr    = 32'h300;
        mem_wr_data    = 32'h55;
        #1;
        chk("t4_bypass_hit", {31'd0, ld_fwd_hit}, 32'd1);
        chk("t4_bypass_data", ld_fwd_data, 32'h55);
        tick();
        mem_wr_en = 1'b0;
        #1;
        chk("t4_fifo_data", ld_fwd_data, 32'h55);

        // Reset during SB_WAIT with three entries; a stray done afterwards must not pop.
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        #1;
        chk("t5_in_wait", {31'd0, dc_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, dc_req_valid}, 32'd0);
        chk("t5_rst_empty", {31'd0, sb_empty}, 32'd1);
        chk("t5_rst_fwd", {31'd0, ld_fwd_hit}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        dc_wr_done = 1'b1;
        tick();
        dc_wr_done = 1'b0;
        tick();
        chk("t5_no_pop_empty", {31'd0, sb_empty}, 32'd1);
        chk("t5_no_pop_stall", {31'd0, sb_stall}, 32'd0);
        commit(32'h500, 32'h77);
        drain_one("t5_after", 32'h500, 32'h77);
        chk("t5_after_empty", {31'd0, sb_empty}, 32'd1);

        // Ten push/drain rounds carry both pointers around the wrap.
        for (int i = 0; i < 10; i++) begin
            commit(32'h600 + 32'(4 * i), 32'h1000 + 32'(i));
            drain_one("t6_wrap", 32'h600 + 32'(4 * i), 32'h1000 + 32'(i));
            chk("t6_empty", {31'd0, sb_empty}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the reorder buffer's memory-write commit port and the data cache write port. It accepts stores retired by the ROB, holds them in a FIFO, and drains them to the cache one at a time through a request/done handshake. It back-pressures the ROB when full and forwards buffered store data to younger loads that look up a matching word address. Committed stores are architectural, so branch flushes do not affect this block.

## Interface
- `SB_DEPTH`, default 4: number of entries; must be a power of two, minimum 2.
- `ADDR_WIDTH`, default 32: store address width in bits.
- `DATA_WIDTH`, default 32: store data width in bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_wr_en`  in  1  ROB commits a store this cycle.
- `mem_wr_addr`  in  ADDR_WIDTH  committed store address; word-aligned.
- `mem_wr_data`  in  DATA_WIDTH  committed store data.
- `sb_stall`  out  1  buffer full; the ROB holds its head store.
- `dc_req_valid`  out  1  write request to the data cache.
- `dc_req_addr`  out  ADDR_WIDTH  head entry address.
- `dc_req_data`  out  DATA_WIDTH  head entry data.
- `dc_req_ready`  in  1  cache accepts the request this cycle.
- `dc_wr_done`  in  1  cache write of the accepted request has completed.
- `ld_lookup_addr`  in  ADDR_WIDTH  load address to check for forwarding.
- `ld_fwd_hit`  out  1  a buffered or incoming store matches `ld_lookup_addr`.
- `ld_fwd_data`  out  DATA_WIDTH  data from the youngest matching store.
- `sb_empty`  out  1  no stores are buffered and no write is in flight.

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are each log2(SB_DEPTH)+1 bits wide.
  - Index = low bits of the pointer.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally.
- `sb_stall` = full, decoded from registered state only.
- Enqueue: when `mem_wr_en & !full`, write {addr, data} at `wr_ptr` and increment it. If `mem_wr_en` arrives while full it is ignored; the ROB retries, because `sb_stall` is high.
- Drain FSM:
  - `SB_IDLE`: `dc_req_valid`=0. Moves to `SB_REQ` when not empty.
  - `SB_REQ`: `dc_req_valid`=1, presenting the head entry. When `dc_req_ready`=1, moves to `SB_WAIT`.
  - `SB_WAIT`: `dc_req_valid`=0. When `dc_wr_done`=1, pops the head (`rd_ptr`+1). Moves to `SB_REQ` if entries remain after the pop (counting a same-cycle enqueue), otherwise to `SB_IDLE`.
- `dc_wr_done` is ignored outside `SB_WAIT`. `dc_req_ready` is ignored outside `SB_REQ`.
- The head entry stays in the buffer, and stays forwardable, until it is popped.
- Forwarding is combinational and compares full word addresses (`addr[ADDR_WIDTH-1:2]`).
  - Search order, highest priority first:
    1. The incoming store on `mem_wr_addr`, if it is accepted this cycle.
    2. Valid entries from youngest (`wr_ptr`-1) to oldest (`rd_ptr`).
  - `ld_fwd_data` = data of the first match; it is 0 when there is no hit.
- `sb_empty` = empty & (state == `SB_IDLE`).

## Timing
- Reset values:
  - `sb_stall`=0, `dc_req_valid`=0, `dc_req_addr`=0, `dc_req_data`=0, `ld_fwd_hit`=0, `ld_fwd_data`=0, `sb_empty`=1.
  - FSM = `SB_IDLE`; pointers = 0; entries cleared.
- Reset asserted mid-operation clears everything immediately, including an in-flight request. `dc_req_valid` drops asynchronously, and the cache must tolerate an abandoned request.
- Enqueue-to-request latency: a store committed at edge N into an empty buffer gives `dc_req_valid`=1 in cycle N+1.
- Throughput: at most one store per cache round trip. Minimum 2 cycles per store (one `SB_REQ` cycle plus one `SB_WAIT` cycle).
- Simultaneous enqueue and pop: occupancy is unchanged.
  - When full, a same-cycle pop does not admit the incoming store.
  - `sb_stall` falls the following cycle and the ROB's retry is accepted then.
- Enqueue-to-forward: the incoming store is visible to forwarding in the same cycle it is accepted. From the next cycle it is visible through the FIFO entry.
- Pop in `SB_WAIT` with count 1 and no enqueue: next state is `SB_IDLE`, and `sb_empty`=1 the cycle after.

## Structure
- Shared package:
  - `sb_entry_t` (addr, data) typedef.
  - `sb_state_t` enum {`SB_IDLE`, `SB_REQ`, `SB_WAIT`}.
  - `SB_DEPTH` and `SB_DEPTH_BITS` constants, next to `ROB_DEPTH`.
- No sub-module is required. The FIFO storage, pointers, FSM and forwarding priority search are all implemented inline. The forwarding search is a loop over entries in age order.

## Test plan
- Reset, then commit a store to 0x100 with data 0xDEAD → `dc_req_valid`=1 the next cycle, with addr 0x100 and data 0xDEAD. Hold `dc_req_ready`=0 for 3 cycles; the request stays stable. Give ready, then `dc_wr_done` → `sb_empty`=1.
- With the cache stalled, commit 4 stores → `sb_stall`=1. A 5th `mem_wr_en` is not enqueued. After one `dc_wr_done`, `sb_stall`=0 and the retried 5th store is accepted. Drain order matches commit order.
- Commit 0x200/0x11 then 0x200/0x22, then look up 0x200 → `ld_fwd_hit`=1 with data 0x22. Look up 0x204 → hit=0 with data 0.
- Commit 0x300/0x55 and look up 0x300 in the same cycle → hit=1 with data 0x55.
- Assert `rst` while in `SB_WAIT` with 3 entries buffered → `dc_req_valid`=0 and `sb_empty`=1 immediately. A later `dc_wr_done` causes no pop and no pointer change.
- Pointer wrap-around: push and drain 10 stores one by one → each store is drained exactly once, with matching addr/data, across the wrap.
